// File: rtl/pwm_spi_pkg.sv
// Shared definitions for the host SPI master and the PWM peripheral's SPI
// bridge: FSM state encoding, frame layout constants and the frame builder.
package pwm_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_RW_BIT = 7;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Byte0 = {rw, 0, addr}; byte1 carries write data, zeros for reads.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] byte0;
    byte0             = '0;
    byte0[CMD_RW_BIT] = write;
    byte0[ADDR_W-1:0] = addr;
    return {byte0, (write ? wdata : {DATA_W{1'b0}})};
  endfunction

endpackage

// File: rtl/spi_host_master_if.sv
// Command/response handshake between host-side logic and the SPI master.
interface spi_host_master_if;
  import pwm_spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  // Host side issues commands and consumes responses.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  // SPI master side accepts commands and produces responses.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period counter for SPI mode 0. sclk is low for the first CLK_DIV
// cycles after enable, then alternates every CLK_DIV cycles. The tick
// strobes mark the cycle on whose closing edge the internal sclk toggles.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             phase_reg;
  logic             half_end;

  assign half_end  = en && (cnt_reg == CNT_W'(CLK_DIV - 1));
  assign rise_tick = half_end && !phase_reg;
  assign fall_tick = half_end && phase_reg;
  assign sclk      = phase_reg;

  // Count half periods while enabled; park low with a cleared count otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (half_end) begin
      cnt_reg   <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 master: one host command becomes one 16-bit frame on the pins.
// The FSM and shift registers run one cycle ahead of the pin registers, so
// cs_n falls the cycle after acceptance and the response pulse lands one
// cycle after GAP entry.
module spi_host_master
  import pwm_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_host_master_if.slave   host,
  output logic               sclk,
  output logic               cs_n,
  output logic               mosi,
  input  logic               miso
);

  localparam int CYC_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS);

  spi_state_e              state_reg, state_next;
  logic [CYC_W-1:0]        cyc_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [FRAME_BITS-1:0]   tx_shift_reg;
  logic [DATA_W-1:0]       rx_shift_reg;
  logic [DATA_W-1:0]       rsp_rdata_reg;
  logic                    rsp_valid_reg;
  logic                    cmd_ready_reg;
  logic                    busy_reg;
  logic                    rise_d_reg;
  logic                    sclk_reg, cs_n_reg, mosi_reg;
  logic                    accept, cyc_last, frame_active;
  logic                    gen_sclk, rise_tick, fall_tick;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state_reg == ST_SHIFT),
    .sclk      (gen_sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign accept       = host.cmd_valid && cmd_ready_reg && (state_reg == ST_IDLE);
  assign frame_active = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD);

  // Terminal count of the timed states.
  always_comb begin
    cyc_last = 1'b0;
    case (state_reg)
      ST_SETUP: cyc_last = (cyc_cnt_reg == CYC_W'(CS_SETUP - 1));
      ST_HOLD:  cyc_last = (cyc_cnt_reg == CYC_W'(CS_HOLD - 1));
      ST_GAP:   cyc_last = (cyc_cnt_reg == CYC_W'(CS_GAP - 1));
      default:  cyc_last = 1'b0;
    endcase
  end

  // Next-state logic; SHIFT ends when the 16th falling half-period completes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SETUP;
      ST_SETUP: if (cyc_last) state_next = ST_SHIFT;
      ST_SHIFT: if (fall_tick && (bit_cnt_reg == BIT_W'(FRAME_BITS - 1))) state_next = ST_HOLD;
      ST_HOLD:  if (cyc_last) state_next = ST_GAP;
      ST_GAP:   if (cyc_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Per-state cycle counter, cleared on every state change and saturating at its terminal count.
  always_ff @(posedge clk) begin
    if (rst || (state_next != state_reg)) begin
      cyc_cnt_reg <= '0;
    end else if (((state_reg == ST_SETUP) || (state_reg == ST_HOLD) || (state_reg == ST_GAP)) && !cyc_last) begin
      cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
    end
  end

  // Bit counter: one count per completed sclk high phase.
  always_ff @(posedge clk) begin
    if (rst || (state_reg != ST_SHIFT)) begin
      bit_cnt_reg <= '0;
    end else if (fall_tick && (bit_cnt_reg != BIT_W'(FRAME_BITS - 1))) begin
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
    end
  end

  // Transmit and receive shift registers; command fields are captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rise_d_reg   <= 1'b0;
    end else begin
      rise_d_reg <= rise_tick;
      if (accept) begin
        tx_shift_reg <= build_frame(host.cmd_write, host.cmd_addr, host.cmd_wdata);
        rx_shift_reg <= '0;
      end else begin
        if (fall_tick) tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
        if (rise_d_reg) rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], miso};
      end
    end
  end

  // Pin registers: miso is sampled on the same edge that raises the sclk pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_reg <= 1'b0;
      cs_n_reg <= 1'b1;
      mosi_reg <= 1'b0;
    end else begin
      sclk_reg <= gen_sclk;
      cs_n_reg <= !frame_active;
      mosi_reg <= frame_active ? tx_shift_reg[FRAME_BITS-1] : 1'b0;
    end
  end

  // Handshake and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      cmd_ready_reg <= (state_next == ST_IDLE);
      busy_reg      <= (state_next != ST_IDLE);
      rsp_valid_reg <= (state_reg == ST_GAP) && (cyc_cnt_reg == '0);
      if ((state_reg == ST_GAP) && (cyc_cnt_reg == '0)) rsp_rdata_reg <= rx_shift_reg;
    end
  end

  assign host.cmd_ready = cmd_ready_reg;
  assign host.busy      = busy_reg;
  assign host.rsp_valid = rsp_valid_reg;
  assign host.rsp_rdata = rsp_rdata_reg;
  assign sclk           = sclk_reg;
  assign cs_n           = cs_n_reg;
  assign mosi           = mosi_reg;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: a register-file SPI slave model behind the
// default-parameter instance, a fixed-pattern miso driver behind a slow
// instance, and a scoreboard of expected frames/latency/read data.
module tb_spi_host_master;
  import pwm_spi_pkg::*;

  localparam int D  = 4, S  = 2, H  = 2, G = 2;
  localparam int D2 = 8, S2 = 3, H2 = 3;
  localparam int LAT    = S + 32 * D + H + 1;
  localparam int CS_LOW = S + 32 * D + H;
  localparam int LAT2   = S2 + 32 * D2 + H2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, cs_n, mosi, miso;
  logic sclk2, cs_n2, mosi2, miso2;

  spi_host_master_if hif();
  spi_host_master_if hif2();

  spi_host_master #(.CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H), .CS_GAP(G)) dut (
    .clk(clk), .rst(rst), .host(hif), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_host_master #(.CLK_DIV(D2), .CS_SETUP(S2), .CS_HOLD(H2), .CS_GAP(G)) dut2 (
    .clk(clk), .rst(rst), .host(hif2), .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_frame;
    logic        chk_rd;
    logic [7:0]  exp_rdata;
  } vec_t;

  typedef struct {
    logic [15:0] frame;
    logic        chk_rd;
    logic [7:0]  rdata;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] got_q[$];
  vec_t        vecs[8];
  logic [7:0]  regs[64];

  int checks = 0, errors = 0, cyc = 0;
  int s_bits = 0, s_idx = 0, cs_low_cnt = 0, gap_cnt = 1000, frame_cnt = 0;
  logic [15:0] s_rx = '0;
  logic [7:0]  s_out = '0;
  logic sclk_p = 1'b0, cs_p = 1'b1, rsp_p = 1'b0;
  int f2 = 0, rise2 = 0;
  logic [15:0] rx2 = '0;
  logic [15:0] pat2 = 16'h005A;
  logic sclk2_p = 1'b0, cs2_p = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // One clock cycle: sample at the falling edge and run the slave models and scoreboard.
  task automatic tick();
    logic s_rise, s_fall, cs_fall, cs_rise, r2, f2e, c2f;
    exp_t e;
    @(negedge clk);
    cyc++;
    s_rise  = sclk && !sclk_p;
    s_fall  = !sclk && sclk_p;
    cs_fall = !cs_n && cs_p;
    cs_rise = cs_n && !cs_p;
    if (s_rise) begin
      check("sclk_rise_with_cs_low", cs_n, 1'b0);
      s_rx = {s_rx[14:0], mosi};
      s_bits++;
    end
    if (s_fall && !cs_n) begin
      if (s_bits == 8) begin
        s_out = s_rx[7] ? 8'h00 : regs[s_rx[5:0]];
        miso  = s_out[7];
        s_idx = 6;
      end else if (s_bits > 8 && s_bits < 16) begin
        miso = s_out[s_idx];
        s_idx--;
      end
    end
    if (cs_fall) begin
      if (frame_cnt > 0) begin
        checks++;
        if (gap_cnt < G) begin
          errors++;
          $display("FAIL cs_gap: got %0d cycles required >= %0d", gap_cnt, G);
        end
      end
      s_bits = 0; s_rx = '0; miso = 1'b0; cs_low_cnt = 0;
    end
    if (cs_rise) begin
      if (s_bits == 16) begin
        got_q.push_back(s_rx);
        frame_cnt++;
        check("cs_low_cycles", cs_low_cnt, CS_LOW);
        if (s_rx[15]) regs[s_rx[13:8]] = s_rx[7:0];
      end
      gap_cnt = 0;
    end
    if (!cs_n) cs_low_cnt++;
    else       gap_cnt++;
    if (hif.rsp_valid) begin
      check("rsp_one_cycle", rsp_p, 1'b0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d required none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_latency", cyc - e.acc_cyc, LAT);
        if (got_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mosi_frame: got no complete frame required 0x%0h", e.frame);
        end else begin
          check("mosi_frame", got_q.pop_front(), e.frame);
        end
        if (e.chk_rd) check("rsp_rdata", hif.rsp_rdata, e.rdata);
      end
    end
    r2  = sclk2 && !sclk2_p;
    f2e = !sclk2 && sclk2_p;
    c2f = !cs_n2 && cs2_p;
    if (c2f) begin
      f2 = 0; rise2 = 0; rx2 = '0; miso2 = pat2[15];
    end
    if (r2) begin
      rx2 = {rx2[14:0], mosi2};
      rise2++;
    end
    if (f2e && !cs_n2) begin
      f2++;
      if (f2 < 16) miso2 = pat2[15 - f2];
    end
    sclk_p = sclk; cs_p = cs_n; rsp_p = hif.rsp_valid;
    sclk2_p = sclk2; cs2_p = cs_n2;
  endtask

  // Present a command and push its expectation once it is accepted.
  task automatic issue(input logic w, input logic [5:0] a, input logic [7:0] d,
                       input logic [15:0] frame, input logic chk, input logic [7:0] rd);
    int n;
    exp_t e;
    hif.cmd_write = w; hif.cmd_addr = a; hif.cmd_wdata = d; hif.cmd_valid = 1'b1;
    n = 0;
    while (!hif.cmd_ready && n < 2000) begin tick(); n++; end
    if (!hif.cmd_ready) begin
      fail_now("accept_timeout");
      hif.cmd_valid = 1'b0;
      return;
    end
    e.frame = frame; e.chk_rd = chk; e.rdata = rd; e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    tick();
    hif.cmd_valid = 1'b0;
    hif.cmd_addr  = ~a;
    hif.cmd_wdata = ~d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || hif.busy) && n < 2000) begin tick(); n++; end
    if (exp_q.size() > 0) fail_now("drain_timeout");
  endtask

  initial begin
    int n, bad, fc0, acc2;
    exp_t e;
    hif.cmd_valid = 1'b0; hif.cmd_write = 1'b0; hif.cmd_addr = '0; hif.cmd_wdata = '0;
    hif2.cmd_valid = 1'b0; hif2.cmd_write = 1'b0; hif2.cmd_addr = '0; hif2.cmd_wdata = '0;
    miso = 1'b0; miso2 = 1'b0;
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;

    vecs[0] = '{1'b1, 6'h00, 8'hA5, 16'h80A5, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 6'h01, 8'h34, 16'h8134, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 6'h01, 8'hEE, 16'h0100, 1'b1, 8'h34};
    vecs[3] = '{1'b1, 6'h3F, 8'h5C, 16'hBF5C, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 6'h3F, 8'h11, 16'h3F00, 1'b1, 8'h5C};
    vecs[5] = '{1'b1, 6'h15, 8'hC3, 16'h95C3, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 6'h15, 8'hFF, 16'h1500, 1'b1, 8'hC3};
    vecs[7] = '{1'b0, 6'h00, 8'h00, 16'h0000, 1'b1, 8'hA5};

    // Reset values.
    repeat (3) tick();
    check("rst_cmd_ready", hif.cmd_ready, 1'b0);
    check("rst_busy", hif.busy, 1'b0);
    check("rst_rsp_valid", hif.rsp_valid, 1'b0);
    check("rst_rsp_rdata", hif.rsp_rdata, 8'h00);
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", hif.cmd_ready, 1'b1);

    // Back-to-back table traffic.
    for (int i = 0; i < 8; i++)
      issue(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_frame, vecs[i].chk_rd, vecs[i].exp_rdata);
    drain();

    // Reset in the middle of SHIFT at bit 8.
    issue(1'b1, 6'h07, 8'h3C, 16'h873C, 1'b0, 8'h00);
    n = 0;
    while (s_bits < 8 && n < 500) begin tick(); n++; end
    if (s_bits < 8) fail_now("reach_bit8");
    rst = 1'b1;
    tick();
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_rsp_valid", hif.rsp_valid, 1'b0);
    check("midrst_rsp_rdata", hif.rsp_rdata, 8'h00);
    check("midrst_busy", hif.busy, 1'b0);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    rst = 1'b0;
    tick();
    issue(1'b1, 6'h02, 8'hFF, 16'h82FF, 1'b0, 8'h00);
    issue(1'b0, 6'h02, 8'h00, 16'h0200, 1'b1, 8'hFF);
    drain();
    repeat (5) tick();

    // cmd_valid held through a frame with a different command on the bus.
    fc0 = frame_cnt;
    hif.cmd_write = 1'b1; hif.cmd_addr = 6'h05; hif.cmd_wdata = 8'h11; hif.cmd_valid = 1'b1;
    n = 0;
    while (!hif.cmd_ready && n < 2000) begin tick(); n++; end
    if (!hif.cmd_ready) fail_now("hold_accept");
    e.frame = 16'h8511; e.chk_rd = 1'b0; e.rdata = 8'h00; e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    tick();
    hif.cmd_write = 1'b0; hif.cmd_addr = 6'h2A; hif.cmd_wdata = 8'h77;
    bad = 0; n = 0;
    while (hif.busy && n < 2000) begin
      if (hif.cmd_ready) bad++;
      tick(); n++;
    end
    hif.cmd_valid = 1'b0;
    check("ready_low_while_busy", bad, 0);
    repeat (20) tick();
    check("single_frame", frame_cnt - fc0, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    // Slow instance read with a fixed miso pattern.
    hif2.cmd_write = 1'b0; hif2.cmd_addr = 6'h10; hif2.cmd_wdata = 8'hC7; hif2.cmd_valid = 1'b1;
    n = 0;
    while (!hif2.cmd_ready && n < 100) begin tick(); n++; end
    if (!hif2.cmd_ready) fail_now("slow_accept");
    acc2 = cyc + 1;
    tick();
    hif2.cmd_valid = 1'b0;
    n = 0;
    while (!hif2.rsp_valid && n < 1000) begin tick(); n++; end
    if (!hif2.rsp_valid) begin
      fail_now("slow_rsp");
    end else begin
      check("slow_latency", cyc - acc2, LAT2);
      check("slow_rdata", hif2.rsp_rdata, 8'h5A);
      check("slow_frame", rx2, 16'h1000);
      check("slow_rises", rise2, 16);
    end
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
